// File: rtl/stream_framer.sv
// Store-and-forward byte-to-word framer: collects one frame of bytes,
// then emits a byte-count header word followed by the packed payload.
module stream_framer #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        upstream_stall,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        downstream_stall,
   output logic        frame_trunc
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [31:0] CAP = 32'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {
      COLLECT,
      HEADER,
      DRAIN
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_count;
   logic [AW-1:0] r_rd_ptr;
   logic [31:0] r_word;
   logic        r_discard;
   logic        r_trunc;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic        w_accept;
   logic        w_store;
   logic [1:0]  w_lane;
   logic [31:0] w_cnt_inc;
   logic        w_cap;
   logic        w_end;
   logic        w_last_word;
   logic [31:0] w_packed;
   logic        w_drain_step;

   assign w_accept  = (r_state == COLLECT) && in_valid;
   assign w_store   = w_accept && !r_discard;
   assign w_lane    = r_count[1:0];
   assign w_cnt_inc = r_count + 32'd1;
   assign w_cap     = w_store && !in_last && (w_cnt_inc == CAP);
   assign w_end     = w_store && (in_last || w_cap);

   // Index of the final payload word is (byte_count-1)/4.
   assign w_last_word =
      ({{(32-AW){1'b0}}, r_rd_ptr} == ((r_count - 32'd1) >> 2));

   assign w_drain_step = (r_state == DRAIN) && !downstream_stall;

   // First byte of a word clears the stale upper lanes.
   assign w_packed =
      ((w_lane == 2'd0) ? 32'd0 : r_word) |
      ({24'd0, in_byte} << {w_lane, 3'b000});

   assign frame_trunc = r_trunc;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= COLLECT;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and handshake/output decode.
   always_comb begin
      w_next         = r_state;
      upstream_stall = 1'b0;
      out_valid      = 1'b0;
      out_data       = 32'd0;
      unique case (r_state)
         COLLECT: begin
            if (w_end) w_next = HEADER;
         end
         HEADER: begin
            upstream_stall = 1'b1;
            out_valid      = 1'b1;
            out_data       = r_count;
            if (!downstream_stall) w_next = DRAIN;
         end
         DRAIN: begin
            upstream_stall = 1'b1;
            out_valid      = 1'b1;
            out_data       = r_mem[r_rd_ptr];
            if (!downstream_stall && w_last_word) w_next = COLLECT;
         end
         default: begin
            w_next = COLLECT;
         end
      endcase
   end

   // Byte count, read pointer, partial word, discard and truncation pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count   <= 32'd0;
         r_rd_ptr  <= '0;
         r_word    <= 32'd0;
         r_discard <= 1'b0;
         r_trunc   <= 1'b0;
      end else begin
         r_trunc <= w_cap;
         if (w_accept && r_discard && in_last) r_discard <= 1'b0;
         if (w_cap) r_discard <= 1'b1;
         if (w_store) begin
            r_count <= w_cnt_inc;
            r_word  <= w_packed;
         end
         if (w_drain_step) begin
            if (w_last_word) begin
               r_rd_ptr <= '0;
               r_count  <= 32'd0;
            end else begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end
      end
   end

   // Payload buffer write on a completed or final word.
   always_ff @(posedge clock) begin
      if (w_store && ((w_lane == 2'd3) || in_last)) begin
         r_mem[r_count[AW+1:2]] <= w_packed;
      end
   end

endmodule

// File: tb/tb_stream_framer.sv
// Scoreboard bench for stream_framer: default-depth and depth-2
// instances, directed frames, stalls, truncation and reset.
module tb_stream_framer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  ib [2];
   logic        iv [2];
   logic        il [2];
   logic        ds [2];
   logic        us [2];
   logic [31:0] od [2];
   logic        ov [2];
   logic        tr [2];

   int total = 0;
   int bad = 0;
   int sel = 0;
   int trc [2];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic        pv [2];
   logic        ps [2];
   logic [31:0] pd [2];

   always #5 clk = ~clk;

   stream_framer u_big (
      .clock(clk), .reset_n(rst_n),
      .in_byte(ib[0]), .in_valid(iv[0]), .in_last(il[0]),
      .upstream_stall(us[0]), .out_data(od[0]), .out_valid(ov[0]),
      .downstream_stall(ds[0]), .frame_trunc(tr[0])
   );

   stream_framer #(.DEPTH_WORDS(2)) u_small (
      .clock(clk), .reset_n(rst_n),
      .in_byte(ib[1]), .in_valid(iv[1]), .in_last(il[1]),
      .upstream_stall(us[1]), .out_data(od[1]), .out_valid(ov[1]),
      .downstream_stall(ds[1]), .frame_trunc(tr[1])
   );

   // Monitor: pops the scoreboard on each transfer, checks stall holds.
   always @(negedge clk) begin
      logic [31:0] e;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            pv[d] = 1'b0;
         end else begin
            if (tr[d]) trc[d]++;
            if (pv[d] && ps[d]) begin
               total++;
               if (!(ov[d] === 1'b1 && od[d] === pd[d])) begin
                  bad++;
                  $display("FAIL hold dut%0d: got v=%0b d=%h want v=1 d=%h",
                           d, ov[d], od[d], pd[d]);
               end
            end
            if (ov[d] && !ds[d]) begin
               total++;
               if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                  bad++;
                  $display("FAIL extra_word dut%0d: got %h want none",
                           d, od[d]);
               end else begin
                  e = (d == 0) ? q0.pop_front() : q1.pop_front();
                  if (od[d] !== e) begin
                     bad++;
                     $display("FAIL word dut%0d: got %h want %h",
                              d, od[d], e);
                  end
               end
            end
            pv[d] = ov[d];
            ps[d] = ds[d];
            pd[d] = od[d];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic push(input logic [31:0] w);
      if (sel == 0) q0.push_back(w);
      else q1.push_back(w);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n = 0;
      @(negedge clk);
      while (us[sel] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL stall_timeout dut%0d: got stall=1 want 0", sel);
      end
      ib[sel] = b;
      iv[sel] = 1'b1;
      il[sel] = last;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [63:0] data, input int n);
      for (int i = 0; i < n; i++) send_byte(data[8*i +: 8], i == n - 1);
      iv[sel] = 1'b0;
      il[sel] = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      int qs;
      do begin
         @(negedge clk);
         n++;
         qs = (sel == 0) ? q0.size() : q1.size();
      end while ((qs != 0 || us[sel]) && n < 500);
      if (n >= 500) begin
         total++;
         bad++;
         $display("FAIL drain_timeout dut%0d: got left=%0d want 0", sel, qs);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         ib[d] = 8'h00; iv[d] = 1'b0; il[d] = 1'b0; ds[d] = 1'b0;
         trc[d] = 0; pv[d] = 1'b0; ps[d] = 1'b0; pd[d] = 32'd0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_valid", {31'd0, ov[d]}, 32'd0);
         check("rst_stall", {31'd0, us[d]}, 32'd0);
         check("rst_trunc", {31'd0, tr[d]}, 32'd0);
         check("rst_data", od[d], 32'd0);
      end
      rst_n = 1'b1;

      // Five-byte frame, back-to-back timing.
      sel = 0;
      push(32'h5); push(32'h44332211); push(32'h55);
      send_frame(64'h55_44332211, 5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t1_valid_run", {31'd0, ov[0]}, 32'd1);
      end
      @(negedge clk);
      check("t1_stall_clear", {31'd0, us[0]}, 32'd0);
      wait_idle();

      // Single byte frame.
      push(32'h1); push(32'hAB);
      send_frame(64'hAB, 1);
      wait_idle();

      // Downstream stalls in header and in second payload word.
      push(32'h5); push(32'h44332211); push(32'h55);
      send_frame(64'h55_44332211, 5);
      ds[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1 ds[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 ds[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1 ds[0] = 1'b0;
      wait_idle();

      // Reset during drain abandons the frame.
      push(32'h5); push(32'h44332211); push(32'h55);
      send_frame(64'h55_44332211, 5);
      @(posedge clk);
      #1 ds[0] = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_valid", {31'd0, ov[0]}, 32'd0);
      check("rst_mid_data", od[0], 32'd0);
      check("rst_mid_stall", {31'd0, us[0]}, 32'd0);
      q0.delete();
      @(negedge clk);
      rst_n = 1'b1;
      ds[0] = 1'b0;
      push(32'h4); push(32'h04030201);
      send_frame(64'h04030201, 4);
      wait_idle();

      // in_valid held with FF while stalled is ignored.
      push(32'h3); push(32'h00CCBBAA);
      send_frame(64'hCCBBAA, 3);
      ib[0] = 8'hFF; iv[0] = 1'b1; il[0] = 1'b0;
      push(32'h1); push(32'h01);
      send_frame(64'h01, 1);
      wait_idle();

      // Truncation on the depth-2 instance.
      sel = 1;
      push(32'h8); push(32'h04030201); push(32'h08070605);
      for (int b = 1; b <= 8; b++) send_byte(8'(b), 1'b0);
      check("trunc_pulse", {31'd0, tr[1]}, 32'd1);
      @(posedge clk);
      #1;
      check("trunc_one_cycle", {31'd0, tr[1]}, 32'd0);
      send_byte(8'h09, 1'b0);
      send_byte(8'h0A, 1'b1);
      iv[1] = 1'b0; il[1] = 1'b0;
      push(32'h1); push(32'h0B);
      send_frame(64'h0B, 1);
      wait_idle();

      // Last byte exactly at capacity: no truncation.
      push(32'h8); push(32'h04030201); push(32'h08070605);
      send_frame(64'h08070605_04030201, 8);
      wait_idle();

      repeat (3) @(negedge clk);
      check("trunc_count_big", 32'(trc[0]), 32'd0);
      check("trunc_count_small", 32'(trc[1]), 32'd1);
      check("q_left_big", 32'(q0.size()), 32'd0);
      check("q_left_small", 32'(q1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_framer.md
STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning payload buffer depth in 32-bit words (power of two, >= 2).
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_byte  input  8  payload byte from the upstream producer.
REQ-005 SHALL have port in_valid  input  1  in_byte is valid this cycle.
REQ-006 SHALL have port in_last  input  1  in_byte is the final byte of the frame.
REQ-007 SHALL have port upstream_stall  output  1  high = producer must hold; byte accepted iff in_valid && !upstream_stall.
REQ-008 SHALL have port out_data  output  32  framed word stream: header word, then payload words.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port downstream_stall  input  1  high = consumer not ready; word transferred iff out_valid && !downstream_stall.
REQ-011 SHALL have port frame_trunc  output  1  one-cycle pulse when a frame is truncated at buffer capacity.

Function
REQ-012 SHALL implement states COLLECT, HEADER and DRAIN, store-and-forward, single buffer.
REQ-013 COLLECT SHALL drive upstream_stall=0 and out_valid=0, accept bytes, and keep a 32-bit byte count of accepted bytes.
REQ-014 Accepted frame byte k SHALL be packed into buffer word k/4 at bits [8*(k%4)+7 : 8*(k%4)] (little-endian, first byte in LSBs).
REQ-015 A word SHALL be written to the buffer on its 4th byte or on the in_last byte; unused upper bytes of a final partial word SHALL be zero.
REQ-016 Accepting a byte with in_last=1 in COLLECT SHALL move to HEADER on the next cycle.
REQ-017 Word count SHALL be ceil(byte_count/4); a frame has at least 1 byte, and a zero-length frame is never emitted.
REQ-018 HEADER SHALL drive out_valid=1 and out_data=byte_count zero-extended to 32 bits, and upstream_stall=1.
REQ-019 A transfer in HEADER SHALL move to DRAIN, with the first payload word presented on the next cycle.
REQ-020 DRAIN SHALL present buffer words in order 0..wordcount-1 with out_valid=1 and upstream_stall=1, advancing one word per transfer.
REQ-021 Transfer of the final payload word SHALL return the block to COLLECT, with byte count and pointers cleared and upstream_stall=0 on the next cycle.
REQ-022 While downstream_stall=1, out_data and out_valid SHALL hold stable; no word is dropped or duplicated.
REQ-023 With downstream_stall held 0, header and payload SHALL issue on consecutive cycles: the header appears the cycle after the last byte is accepted, and wordcount+1 cycles are needed to drain.
REQ-024 in_valid SHALL be ignored while upstream_stall=1.
REQ-025 Truncation: if an accepted byte with in_last=0 brings byte_count to 4*DEPTH_WORDS, the block SHALL pulse frame_trunc for 1 cycle, set a discard flag and enter HEADER exactly as if in_last were set.
REQ-026 In COLLECT with the discard flag set, bytes SHALL be accepted and dropped until, and including, the next byte with in_last=1, after which the flag clears.
REQ-027 A byte accepted with in_last=1 exactly at capacity SHALL NOT raise frame_trunc.

Reset
REQ-028 reset_n=0 SHALL asynchronously force COLLECT, byte count 0, pointers 0, discard flag 0, out_valid=0, upstream_stall=0, frame_trunc=0 and out_data=0.
REQ-029 A reset asserted mid-frame (any state) SHALL abandon that frame entirely; no partial header or payload is emitted after release.
REQ-030 Buffer contents need no reset.

Verification
REQ-031 Bytes 11,22,33,44,55(last), no stall -> 0x00000005, 0x44332211, 0x00000055 on 3 consecutive cycles, then upstream_stall=0.
REQ-032 Single byte AB(last) -> 0x00000001, then 0x000000AB.
REQ-033 Frame of REQ-031 with downstream_stall=1 for 3 cycles during HEADER and 2 cycles during word 1 -> values held stable, same 3 words exactly once each.
REQ-034 DEPTH_WORDS=2, bytes 01..0A with last on 0A -> frame_trunc pulse on the cycle after byte 08 is accepted; out 0x00000008, 0x04030201, 0x08070605; bytes 09,0A dropped; next frame 0B(last) -> 0x00000001, 0x0000000B.
REQ-035 reset_n low during DRAIN -> out_valid=0 immediately with no clock; after release, frame 01,02,03,04(last) -> 0x00000004, 0x04030201.
REQ-036 in_valid=1 with in_byte=FF held throughout HEADER/DRAIN -> no FF appears in output and the next frame's count is unaffected.
